// File: rtl/pmem_burst_bridge_pkg.sv
// pmem_burst_bridge_pkg: lc3b line/word/beat types shared by the burst bridge.
// Rev 1.0
`default_nettype none

package pmem_burst_bridge_pkg;
    localparam int LINE_WIDTH         = 256;
    localparam int DEFAULT_BEAT_WIDTH = 64;
    localparam int LINE_OFFSET_BITS   = 5;

    typedef logic [15:0]                   lc3b_word;
    typedef logic [LINE_WIDTH-1:0]         lc3b_c2_line;
    typedef logic [DEFAULT_BEAT_WIDTH-1:0] lc3b_beat;
endpackage

`default_nettype wire

// File: rtl/pmem_burst_bridge_if.sv
// pmem_burst_bridge_if: line-side (EWB) and beat-side (pmem bus) signals of the bridge.
// Rev 1.0
`default_nettype none

interface pmem_burst_bridge_if #(
    parameter int BEAT_WIDTH = 64
);
    import pmem_burst_bridge_pkg::*;

    logic                  line_read;
    logic                  line_write;
    lc3b_word              line_address;
    lc3b_c2_line           line_wdata;
    logic                  line_resp;
    lc3b_c2_line           line_rdata;
    logic                  bus_read;
    logic                  bus_write;
    lc3b_word              bus_address;
    logic [BEAT_WIDTH-1:0] bus_wdata;
    logic                  bus_resp;
    logic [BEAT_WIDTH-1:0] bus_rdata;

    // Bridge view
    modport slave (
        input  line_read, line_write, line_address, line_wdata, bus_resp, bus_rdata,
        output line_resp, line_rdata, bus_read, bus_write, bus_address, bus_wdata
    );

    // Upstream + memory model view
    modport master (
        output line_read, line_write, line_address, line_wdata, bus_resp, bus_rdata,
        input  line_resp, line_rdata, bus_read, bus_write, bus_address, bus_wdata
    );
endinterface

`default_nettype wire

// File: rtl/pmem_burst_bridge_line_beat_mux.sv
// line_beat_mux: selects beat slice i_sel of a 256-bit line.
// Rev 1.0
`default_nettype none

module line_beat_mux
    import pmem_burst_bridge_pkg::*;
#(
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 4,
    parameter int CNT_W      = 2
) (
    input  lc3b_c2_line           i_line,
    input  logic [CNT_W-1:0]      i_sel,
    output logic [BEAT_WIDTH-1:0] o_beat
);
    always_comb begin
        o_beat = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (i_sel == CNT_W'(b)) begin
                o_beat = i_line[b*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/pmem_burst_bridge.sv
// pmem_burst_bridge: splits line requests into in-order bus beat bursts and reassembles reads.
// Optional perf counters via PMEM_BRIDGE_PERF_EN. Rev 1.0
`default_nettype none

module pmem_burst_bridge
    import pmem_burst_bridge_pkg::*;
#(
    parameter int BEAT_WIDTH = DEFAULT_BEAT_WIDTH
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    pmem_burst_bridge_if.slave      bif
`ifdef PMEM_BRIDGE_PERF_EN
    ,
    output logic [15:0]             perf_read_count,
    output logic [15:0]             perf_write_count
`endif
);
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_BURST  = 2'd1,
        WRITE_BURST = 2'd2,
        DONE        = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    lc3b_word              r_addr;
    lc3b_c2_line           r_line;
    lc3b_c2_line           r_rdata;
    logic                  r_is_read;
    logic                  w_last;
    lc3b_word              w_aligned;
    lc3b_c2_line           w_line_asm;
    logic [BEAT_WIDTH-1:0] w_beat;

    assign w_last    = (r_cnt == CNT_W'(BEATS - 1));
    assign w_aligned = bif.line_address & ~lc3b_word'({LINE_OFFSET_BITS{1'b1}});

    line_beat_mux #(
        .BEAT_WIDTH (BEAT_WIDTH),
        .BEATS      (BEATS),
        .CNT_W      (CNT_W)
    ) u_beat_mux (
        .i_line (r_line),
        .i_sel  (r_cnt),
        .o_beat (w_beat)
    );

    // Read assembly: drop the incoming beat into slot r_cnt of the line buffer
    always_comb begin
        w_line_asm = r_line;
        for (int b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b)) begin
                w_line_asm[b*BEAT_WIDTH +: BEAT_WIDTH] = bif.bus_rdata;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bif.line_write) begin
                    w_state_next = WRITE_BURST;
                end else if (bif.line_read) begin
                    w_state_next = READ_BURST;
                end
            end
            READ_BURST, WRITE_BURST: begin
                if (bif.bus_resp && w_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Bus strobes decode straight from state so an async reset drops them at once
    assign bif.bus_read    = (r_state == READ_BURST);
    assign bif.bus_write   = (r_state == WRITE_BURST);
    assign bif.line_resp   = (r_state == DONE);
    assign bif.bus_wdata   = (r_state == WRITE_BURST) ? w_beat : '0;
    assign bif.bus_address = r_addr;
    assign bif.line_rdata  = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_line    <= '0;
            r_rdata   <= '0;
            r_is_read <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (bif.line_write) begin
                        r_line    <= bif.line_wdata;
                        r_addr    <= w_aligned;
                        r_cnt     <= '0;
                        r_is_read <= 1'b0;
                    end else if (bif.line_read) begin
                        r_addr    <= w_aligned;
                        r_cnt     <= '0;
                        r_is_read <= 1'b1;
                    end
                end
                READ_BURST: begin
                    if (bif.bus_resp) begin
                        r_line <= w_line_asm;
                        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) begin
                            r_rdata <= w_line_asm;
                        end
                    end
                end
                WRITE_BURST: begin
                    if (bif.bus_resp) begin
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PMEM_BRIDGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_read_count  <= '0;
            perf_write_count <= '0;
        end else if (r_state == DONE) begin
            if (r_is_read && (perf_read_count != 16'hFFFF)) begin
                perf_read_count <= perf_read_count + 16'd1;
            end
            if (!r_is_read && (perf_write_count != 16'hFFFF)) begin
                perf_write_count <= perf_write_count + 16'd1;
            end
        end
    end
`endif
endmodule

`default_nettype wire

// File: tb/tb_pmem_burst_bridge.sv
// tb_pmem_burst_bridge: directed self-checking bench for pmem_burst_bridge.
// Rev 1.0
`default_nettype none

module tb_pmem_burst_bridge;
    import pmem_burst_bridge_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pmem_burst_bridge_if #(.BEAT_WIDTH(64)) bif ();

`ifdef PMEM_BRIDGE_PERF_EN
    logic [15:0] perf_read_count;
    logic [15:0] perf_write_count;
`endif

    pmem_burst_bridge #(.BEAT_WIDTH(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bif              (bif)
`ifdef PMEM_BRIDGE_PERF_EN
        ,
        .perf_read_count  (perf_read_count),
        .perf_write_count (perf_write_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts a read, returns four back-to-back beats and checks the assembled line
    task automatic run_read(input string tag, input lc3b_word addr, input lc3b_word exp_addr,
                            input lc3b_beat b0, input lc3b_beat b1,
                            input lc3b_beat b2, input lc3b_beat b3);
        lc3b_beat beats [4];
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        bif.line_address = addr;
        bif.line_read    = 1'b1;
        step();
        check({tag, "_bus_read"}, bif.bus_read, 1'b1);
        check({tag, "_bus_addr"}, bif.bus_address, exp_addr);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_no_early_resp"}, bif.line_resp, 1'b0);
            bif.bus_resp  = 1'b1;
            bif.bus_rdata = beats[i];
            step();
        end
        bif.bus_resp  = 1'b0;
        check({tag, "_line_resp"}, bif.line_resp, 1'b1);
        check({tag, "_bus_read_done"}, bif.bus_read, 1'b0);
        check({tag, "_rdata"}, bif.line_rdata, {b3, b2, b1, b0});
        bif.line_read = 1'b0;
        step();
        check({tag, "_resp_single"}, bif.line_resp, 1'b0);
        check({tag, "_rdata_hold"}, bif.line_rdata, {b3, b2, b1, b0});
    endtask

    lc3b_beat    wb [4];
    lc3b_c2_line wline;
    lc3b_c2_line rline1;
    lc3b_c2_line rline2;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bif.line_read    = 1'b0;
        bif.line_write   = 1'b0;
        bif.line_address = '0;
        bif.line_wdata   = '0;
        bif.bus_resp     = 1'b0;
        bif.bus_rdata    = '0;
        wb[0] = 64'hA5A5A5A5_00000000;
        wb[1] = 64'hA5A5A5A5_11111111;
        wb[2] = 64'hA5A5A5A5_22222222;
        wb[3] = 64'hA5A5A5A5_33333333;
        wline  = {wb[3], wb[2], wb[1], wb[0]};
        rline1 = {64'h4444444444444444, 64'h3333333333333333,
                  64'h2222222222222222, 64'h1111111111111111};
        rline2 = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                  64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};

        // Reset values
        step();
        step();
        check("rst_line_resp", bif.line_resp, 1'b0);
        check("rst_bus_read", bif.bus_read, 1'b0);
        check("rst_bus_write", bif.bus_write, 1'b0);
        check("rst_bus_addr", bif.bus_address, 16'h0000);
        check("rst_bus_wdata", bif.bus_wdata, 64'h0);
        check("rst_line_rdata", bif.line_rdata, 256'h0);
        rst_n = 1'b1;
        step();

        // Read 0x1240, back-to-back beats; line_resp in the 6th cycle counting the request cycle
        run_read("rd1240", 16'h1240, 16'h1240,
                 64'h1111111111111111, 64'h2222222222222222,
                 64'h3333333333333333, 64'h4444444444444444);

        // Write 0x2A3F, upstream mutates request after acceptance, 2-cycle beat spacing
        bif.line_address = 16'h2A3F;
        bif.line_wdata   = wline;
        bif.line_write   = 1'b1;
        step();
        bif.line_wdata   = '1;
        bif.line_address = 16'hFFFF;
        check("wr_bus_write", bif.bus_write, 1'b1);
        check("wr_bus_read", bif.bus_read, 1'b0);
        check("wr_bus_addr", bif.bus_address, 16'h2A20);
        for (int i = 0; i < 4; i++) begin
            check("wr_beat_gap", bif.bus_wdata, wb[i]);
            step();
            check("wr_beat_held", bif.bus_wdata, wb[i]);
            bif.bus_resp = 1'b1;
            step();
            bif.bus_resp = 1'b0;
        end
        check("wr_line_resp", bif.line_resp, 1'b1);
        check("wr_bus_write_done", bif.bus_write, 1'b0);
        check("wr_rdata_unchanged", bif.line_rdata, rline1);
        bif.line_write = 1'b0;
        step();
        check("wr_resp_single", bif.line_resp, 1'b0);

        // Read and write together: write wins, held read follows
        bif.line_address = 16'h0100;
        bif.line_wdata   = wline;
        bif.line_write   = 1'b1;
        bif.line_read    = 1'b1;
        step();
        check("both_write_first", bif.bus_write, 1'b1);
        check("both_no_read", bif.bus_read, 1'b0);
        check("both_addr", bif.bus_address, 16'h0100);
        for (int i = 0; i < 4; i++) begin
            check("both_wbeat", bif.bus_wdata, wb[i]);
            bif.bus_resp = 1'b1;
            step();
        end
        bif.bus_resp = 1'b0;
        check("both_wr_resp", bif.line_resp, 1'b1);
        bif.line_write = 1'b0;
        step();
        check("both_idle_gap", bif.bus_read, 1'b0);
        step();
        check("both_read_next", bif.bus_read, 1'b1);
        check("both_read_addr", bif.bus_address, 16'h0100);
        for (int i = 0; i < 4; i++) begin
            bif.bus_resp  = 1'b1;
            bif.bus_rdata = rline2[i*64 +: 64];
            step();
        end
        bif.bus_resp = 1'b0;
        check("both_rd_resp", bif.line_resp, 1'b1);
        check("both_rdata", bif.line_rdata, rline2);
        bif.line_read = 1'b0;
        step();

        // Reset after two beats of a read
        bif.line_address = 16'h3000;
        bif.line_read    = 1'b1;
        step();
        check("rst_mid_bus_read", bif.bus_read, 1'b1);
        for (int i = 0; i < 2; i++) begin
            bif.bus_resp  = 1'b1;
            bif.bus_rdata = 64'h5555555555555555;
            step();
        end
        bif.bus_resp = 1'b0;
        check("rst_mid_partial_hidden", bif.line_rdata, rline2);
        check("rst_mid_no_resp_yet", bif.line_resp, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_bus_read_low", bif.bus_read, 1'b0);
        check("rst_mid_no_resp", bif.line_resp, 1'b0);
        check("rst_mid_rdata_cleared", bif.line_rdata, 256'h0);
        bif.line_read = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Spurious bus_resp while idle
        bif.bus_resp  = 1'b1;
        bif.bus_rdata = 64'hFFFFFFFFFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("spur_no_resp", bif.line_resp, 1'b0);
            check("spur_no_read", bif.bus_read, 1'b0);
            check("spur_no_write", bif.bus_write, 1'b0);
        end
        bif.bus_resp = 1'b0;
        check("spur_rdata", bif.line_rdata, 256'h0);

        // Beat ordering intact after the spurious responses
        run_read("rd0047", 16'h0047, 16'h0040,
                 64'h0101010101010101, 64'h0202020202020202,
                 64'h0303030303030303, 64'h0404040404040404);

`ifdef PMEM_BRIDGE_PERF_EN
        check("perf_reads", perf_read_count, 16'd1);
        check("perf_writes", perf_write_count, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
